cardio_classifier: RTL and testbench
====================================

Name: cardio_classifier

Overview:
- Registered 3-class linear (one-vs-rest argmax) classifier for the Cardio feature set.
- Takes 21 unsigned 4-bit quantized features packed into one bus.
- Computes a signed score per class and outputs the index of the highest score.
- Sits between the feature-quantization front end and the result logger; one decision per accepted input vector.

Parameters:
- NUM_A, 21, number of input features.
- WIDTH_A, 4, bits per feature (unsigned).
- OUTWIDTH, 2, width of the class index.
- W0, see Behaviour, class-0 weights: NUM_A packed signed 4-bit values, feature i at bits [4i+3:4i].
- W1, see Behaviour, class-1 weights, same packing as W0.
- W2, see Behaviour, class-2 weights, same packing as W0.
- B0, +8, class-0 bias, signed 8-bit.
- B1, 0, class-1 bias, signed 8-bit.
- B2, -8, class-2 bias, signed 8-bit.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- inp  input  NUM_A*WIDTH_A (84)  feature vector; feature i = inp[(i+1)*WIDTH_A-1 : i*WIDTH_A].
- in_valid  input  1  inp is sampled when high.
- out  output  OUTWIDTH (2)  predicted class: 0, 1 or 2.
- out_valid  output  1  out holds a new result.

Behaviour:
- Features f_i are unsigned, range 0..15.
- Default weights:
  - W0 = +1 for f0–f6, −1 for f7–f13, 0 for f14–f20.
  - W1 = 0 for f0–f6, +1 for f7–f13, −1 for f14–f20.
  - W2 = −1 for f0–f6, 0 for f7–f13, +1 for f14–f20.
- Score: s_c = B_c + Σ_i W_c[i]·f_i, computed in 14-bit signed two's complement.
  - Maximum magnitude is 21·15·8 + 128 = 2648, so no overflow and no saturation.
  - Each f_i is zero-extended before multiplying by its sign-extended weight.
- Argmax: out = index of the largest s_c.
  - Ties resolve to the lowest index: s0 ≥ s1 and s0 ≥ s2 → 0; else s1 ≥ s2 → 1; else 2.
  - Value 3 is never produced.
- Timing, latency 1 cycle:
  - At a rising edge with rst_n=1 and in_valid=1: out ← argmax(inp), out_valid ← 1.
  - At a rising edge with rst_n=1 and in_valid=0: out holds its value, out_valid ← 0.
- Score and argmax datapath is purely combinational from inp; the only state is the out and out_valid registers.
- Reset: at a rising edge with rst_n=0, out ← 0 and out_valid ← 0.
  - Reset has priority over in_valid.
  - A vector presented during the reset cycle is discarded.
  - Deasserting reset produces no spurious out_valid.
- Back-to-back: in_valid may be high every cycle; each cycle's vector yields its result exactly one cycle later. There is no backpressure.
- Unknown or X inputs are not required to be handled.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with in_valid=1 and random inp → out=0 and out_valid=0 throughout; first cycle after release with in_valid=0 → out_valid=0.
- Extremes:
  - All features 0 → scores (8, 0, −8) → out=0, one cycle later.
  - All features 15 → scores (8, 0, −8) → out=0.
- Class 1 and class 2:
  - f7..f13=15, others 0 → scores (−97, 105, −8) → out=1.
  - f14..f20=15, others 0 → scores (8, −105, 97) → out=2.
- Tie-break:
  - f7=1, f14=15, others 0 → scores (7, −14, 7) → out=0.
  - f14=8, others 0 → scores (8, −8, 0) → out=0.
- Streaming: the four vectors above on consecutive cycles with in_valid=1 → out sequence 0, 1, 2, 0 and out_valid high for 4 consecutive cycles, each result one cycle after its input.
- Hold/random:
  - Drop in_valid for 3 cycles → out holds its last value, out_valid=0.
  - Then run 1000 random vectors checked against a reference score/argmax model, including an rst_n pulse mid-stream → out=0 and out_valid=0 the next cycle.

Source files
------------

// File: rtl/cardio_classifier.sv
// Registered 3-class one-vs-rest linear classifier over 21 unsigned 4-bit features.
// Scores and argmax are combinational from inp; only the class index and valid flag are stored.
module cardio_classifier #(
    parameter int unsigned NUM_A    = 21,
    parameter int unsigned WIDTH_A  = 4,
    parameter int unsigned OUTWIDTH = 2,
    parameter logic [NUM_A*WIDTH_A-1:0] W0 = 84'h0000000_FFFFFFF_1111111,
    parameter logic [NUM_A*WIDTH_A-1:0] W1 = 84'hFFFFFFF_1111111_0000000,
    parameter logic [NUM_A*WIDTH_A-1:0] W2 = 84'h1111111_0000000_FFFFFFF,
    parameter logic signed [7:0]        B0 = 8'sd8,
    parameter logic signed [7:0]        B1 = 8'sd0,
    parameter logic signed [7:0]        B2 = -8'sd8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_A*WIDTH_A-1:0] inp,
    input  logic                     in_valid,
    output logic [OUTWIDTH-1:0]      out,
    output logic                     out_valid
);

    localparam int unsigned FW = NUM_A * WIDTH_A;
    localparam int unsigned SW = 14;

    logic signed [SW-1:0] score0_c;
    logic signed [SW-1:0] score1_c;
    logic signed [SW-1:0] score2_c;
    logic [OUTWIDTH-1:0]  cls_c;

    logic [OUTWIDTH-1:0]  out_d;
    logic [OUTWIDTH-1:0]  out_q;
    logic                 out_valid_d;
    logic                 out_valid_q;

    // Bias plus dot product of zero-extended features with sign-extended weights.
    function automatic logic signed [SW-1:0] class_score(
        input logic [FW-1:0]       w,
        input logic signed [7:0]   b,
        input logic [FW-1:0]       f
    );
        logic signed [SW-1:0]      acc;
        logic signed [WIDTH_A-1:0] wi;
        logic signed [SW-1:0]      wx;
        logic signed [SW-1:0]      fx;
        acc = SW'(b);
        for (int unsigned i = 0; i < NUM_A; i++) begin
            wi  = w[i*WIDTH_A +: WIDTH_A];
            wx  = SW'(wi);
            fx  = SW'(f[i*WIDTH_A +: WIDTH_A]);
            acc = acc + fx * wx;
        end
        return acc;
    endfunction

    always_comb begin
        score0_c = class_score(W0, B0, inp);
        score1_c = class_score(W1, B1, inp);
        score2_c = class_score(W2, B2, inp);
    end

    // Argmax with ties going to the lowest class index.
    always_comb begin
        cls_c = OUTWIDTH'(2);
        if ((score0_c >= score1_c) && (score0_c >= score2_c)) begin
            cls_c = OUTWIDTH'(0);
        end else if (score1_c >= score2_c) begin
            cls_c = OUTWIDTH'(1);
        end
    end

    always_comb begin
        out_d       = out_q;
        out_valid_d = 1'b0;
        if (in_valid) begin
            out_d       = cls_c;
            out_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_cardio_classifier.sv
// Self-checking bench for cardio_classifier: directed vector table, streaming and hold
// sequences, then randomized traffic against a group-based score/argmax reference model.
module tb_cardio_classifier;

    localparam int unsigned NF = 21;
    localparam int unsigned FB = 4;

    logic             clk;
    logic             rst_n;
    logic [NF*FB-1:0] inp;
    logic             in_valid;
    logic [1:0]       out;
    logic             out_valid;

    int n_total;
    int n_pass;

    cardio_classifier dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .inp       (inp),
        .in_valid  (in_valid),
        .out       (out),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string            name;
        logic [NF*FB-1:0] vec;
        logic [1:0]       exp_out;
    } vec_t;

    vec_t tbl[6];

    // Reference: features fall in three groups of seven; each class weights a group +1, -1 or 0.
    function automatic int ref_class(input logic [NF*FB-1:0] v);
        int wt[3][3];
        int bias[3];
        int s[3];
        wt   = '{'{1, -1, 0}, '{0, 1, -1}, '{-1, 0, 1}};
        bias = '{8, 0, -8};
        for (int c = 0; c < 3; c++) begin
            s[c] = bias[c];
            for (int i = 0; i < int'(NF); i++)
                s[c] += wt[c][i / 7] * int'(v[i*FB +: FB]);
        end
        if (s[0] >= s[1] && s[0] >= s[2]) return 0;
        if (s[1] >= s[2]) return 1;
        return 2;
    endfunction

    function automatic logic [NF*FB-1:0] mk(input int lo, input int hi, input int val);
        logic [NF*FB-1:0] v;
        v = '0;
        for (int i = lo; i <= hi; i++) v[i*FB +: FB] = 4'(val);
        return v;
    endfunction

    function automatic logic [NF*FB-1:0] rand_vec();
        logic [NF*FB-1:0] v;
        bit               extreme;
        extreme = ($urandom_range(3) == 0);
        for (int i = 0; i < int'(NF); i++) begin
            if (extreme) v[i*FB +: FB] = ($urandom_range(1) == 1) ? 4'hF : 4'h0;
            else         v[i*FB +: FB] = 4'($urandom_range(15));
        end
        return v;
    endfunction

    task automatic check(input string name, input int act, input int req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    endtask

    // Advance to just after the next rising edge.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int last_out;
        int exp_out;
        int exp_valid;
        int seq[4];
        logic [NF*FB-1:0] nv;

        n_total = 0;
        n_pass  = 0;

        tbl[0] = '{"all_zero",  mk(0, 20, 0),                  2'd0};
        tbl[1] = '{"all_max",   mk(0, 20, 15),                 2'd0};
        tbl[2] = '{"class1",    mk(7, 13, 15),                 2'd1};
        tbl[3] = '{"class2",    mk(14, 20, 15),                2'd2};
        tbl[4] = '{"tie_0_2",   mk(7, 7, 1) | mk(14, 14, 15),  2'd0};
        tbl[5] = '{"f14_eq_8",  mk(14, 14, 8),                 2'd0};

        // Reset held with valid traffic present
        rst_n    = 1'b0;
        in_valid = 1'b1;
        inp      = rand_vec();
        #1;
        for (int k = 0; k < 2; k++) begin
            inp = rand_vec();
            cycle();
            check("rst_out", int'(out), 0);
            check("rst_valid", int'(out_valid), 0);
        end
        rst_n    = 1'b1;
        in_valid = 1'b0;
        cycle();
        check("post_rst_valid", int'(out_valid), 0);
        check("post_rst_out", int'(out), 0);

        // Directed table: one vector, then an idle cycle that must hold out
        foreach (tbl[k]) begin
            inp      = tbl[k].vec;
            in_valid = 1'b1;
            cycle();
            check({tbl[k].name, "_out"}, int'(out), int'(tbl[k].exp_out));
            check({tbl[k].name, "_valid"}, int'(out_valid), 1);
            in_valid = 1'b0;
            inp      = rand_vec();
            cycle();
            check({tbl[k].name, "_idle_valid"}, int'(out_valid), 0);
            check({tbl[k].name, "_idle_hold"}, int'(out), int'(tbl[k].exp_out));
        end

        // Back-to-back streaming
        seq = '{0, 2, 3, 4};
        in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            inp = tbl[seq[k]].vec;
            cycle();
            check("stream_out", int'(out), int'(tbl[seq[k]].exp_out));
            check("stream_valid", int'(out_valid), 1);
        end
        last_out = int'(tbl[seq[3]].exp_out);

        // Put a class-1 result in out so the hold check is non-trivial
        inp = tbl[2].vec;
        cycle();
        check("pre_hold_out", int'(out), 1);
        last_out = 1;

        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            inp = rand_vec();
            cycle();
            check("hold_out", int'(out), last_out);
            check("hold_valid", int'(out_valid), 0);
        end

        // Randomized traffic with a reset pulse mid-stream
        exp_out   = last_out;
        exp_valid = 0;
        for (int k = 0; k < 1000; k++) begin
            nv       = rand_vec();
            inp      = nv;
            in_valid = ($urandom_range(3) != 0);
            rst_n    = !(k == 500 || k == 501);
            if (!rst_n) begin
                exp_out   = 0;
                exp_valid = 0;
            end else if (in_valid) begin
                exp_out   = ref_class(nv);
                exp_valid = 1;
            end else begin
                exp_valid = 0;
            end
            cycle();
            check(rst_n ? "rand_out" : "rand_rst_out", int'(out), exp_out);
            check(rst_n ? "rand_valid" : "rand_rst_valid", int'(out_valid), exp_valid);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
